// File: rtl/ser_shift_ctrl_pkg.sv
// Shared types and helpers for the parallel-to-serial shift controller.
package ser_shift_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Bit counter only has to reach width-1, and never narrower than one bit.
  function automatic int bit_cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/ser_shift_ctrl_shift_stage.sv
// Loadable bidirectional shift register with zero fill; load wins over shift.
module shift_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             dir,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // NOTE: this is a register bank of plain flops, not a RAM, so it can and does take the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (load) begin
      // NOTE: non-blocking here so every flop samples pre-edge values, whatever the statement order.
      r_q <= d;
    end else if (en) begin
      r_q <= dir ? {r_q[WIDTH-2:0], 1'b0} : {1'b0, r_q[WIDTH-1:1]};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/ser_shift_ctrl.sv
// Valid/ready word intake, bit-period timing and frame sequencing around shift_stage.
module ser_shift_ctrl
  import ser_shift_ctrl_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter int   DIV_W    = 16,
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_msb_first,
  input  logic [DIV_W-1:0] div,
  input  logic             abort,
  output logic             ser_out,
  output logic             bit_tick,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = bit_cnt_width(WIDTH);

  state_t           r_state;
  logic             r_dir;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_baud_cnt;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_tick;
  logic             w_last;
  logic             w_shift_en;
  logic [WIDTH-1:0] w_q;

  assign w_accept   = (r_state == S_IDLE) && s_valid && !abort;
  assign w_tick     = (r_state == S_SHIFT) && (r_baud_cnt == r_div);
  assign w_last     = w_tick && (r_bit_cnt == CNT_W'(WIDTH - 1));
  assign w_shift_en = w_tick && !abort;

  shift_stage #(
    .WIDTH (WIDTH)
  ) u_shift_stage (
    .clk  (clk),
    .rst  (rst),
    .load (w_accept),
    .en   (w_shift_en),
    .dir  (r_dir),
    .d    (s_data),
    .q    (w_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_dir      <= 1'b0;
      r_div      <= '0;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= S_SHIFT;
            r_busy     <= 1'b1;
            r_dir      <= s_msb_first;
            r_div      <= div;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_tick) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Direction selects which end of the shift stage feeds the pin.
  assign ser_out  = (r_state == S_SHIFT) ? (r_dir ? w_q[WIDTH-1] : w_q[0]) : IDLE_LVL;
  assign s_ready  = (r_state == S_IDLE) && !abort;
  assign bit_tick = w_tick;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_ser_shift_ctrl.sv
// Directed-vector bench for ser_shift_ctrl (WIDTH=8, idle level 1).
module tb_ser_shift_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_msb_first;
  logic [15:0] div;
  logic        abort;
  logic        ser_out;
  logic        bit_tick;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  ser_shift_ctrl #(
    .WIDTH    (8),
    .DIV_W    (16),
    .IDLE_LVL (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_msb_first (s_msb_first),
    .div         (div),
    .abort       (abort),
    .ser_out     (ser_out),
    .bit_tick    (bit_tick),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; offers a word and returns just after the accepting edge.
  task automatic send(input string tag, input logic [7:0] data, input logic msb,
                      input logic [15:0] dv, input logic hold);
    s_data      = data;
    s_msb_first = msb;
    div         = dv;
    s_valid     = 1'b1;
    #1;
    check({tag, " ready"}, s_ready, 1'b1);
    @(posedge clk);
    #1 s_valid = hold;
  endtask

  // seq[7] is the first bit on the wire. Samples cycles 1..8P+2 after the accepting edge.
  task automatic expect_frame(input string tag, input logic [7:0] seq, input int p,
                              input logic drop_valid, input logic [7:0] nxt_data,
                              input logic nxt_msb, input logic [15:0] nxt_div);
    for (int j = 1; j <= 8 * p; j++) begin
      @(negedge clk);
      check($sformatf("%s c%0d ser", tag, j), ser_out, seq[7 - (j - 1) / p]);
      check($sformatf("%s c%0d tick", tag, j), bit_tick, (j % p) == 0);
      check($sformatf("%s c%0d busy", tag, j), busy, 1'b1);
      check($sformatf("%s c%0d done", tag, j), done, 1'b0);
      check($sformatf("%s c%0d rdy", tag, j), s_ready, 1'b0);
      if (j == 2) begin
        s_data      = ~s_data;
        s_msb_first = ~s_msb_first;
        div         = (div == 16'd0) ? 16'd3 : 16'd0;
        if (drop_valid) s_valid = 1'b0;
      end
    end
    @(negedge clk);
    check({tag, " dn done"}, done, 1'b1);
    check({tag, " dn ser"}, ser_out, 1'b1);
    check({tag, " dn rdy"}, s_ready, 1'b0);
    check({tag, " dn busy"}, busy, 1'b1);
    check({tag, " dn tick"}, bit_tick, 1'b0);
    s_data      = nxt_data;
    s_msb_first = nxt_msb;
    div         = nxt_div;
    @(negedge clk);
    check({tag, " end done"}, done, 1'b0);
    check({tag, " end busy"}, busy, 1'b0);
    check({tag, " end rdy"}, s_ready, 1'b1);
  endtask

  initial begin
    rst         = 1'b1;
    s_valid     = 1'b0;
    s_data      = 8'h00;
    s_msb_first = 1'b1;
    div         = 16'd0;
    abort       = 1'b0;
    repeat (2) @(negedge clk);
    check("rst ready", s_ready, 1'b1);
    check("rst ser", ser_out, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst tick", bit_tick, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // 0x0F MSB-first, one bit per clock
    send("f0", 8'h0F, 1'b1, 16'd0, 1'b0);
    expect_frame("f0", 8'b0000_1111, 1, 1'b1, 8'h00, 1'b0, 16'd0);

    // 0x0F LSB-first; direction flip mid-frame must not matter
    send("f1", 8'h0F, 1'b0, 16'd0, 1'b0);
    expect_frame("f1", 8'b1111_0000, 1, 1'b1, 8'h00, 1'b0, 16'd0);

    // 0x81 MSB-first, four clocks per bit; div dropped to 0 mid-frame
    send("f2", 8'h81, 1'b1, 16'd3, 1'b0);
    expect_frame("f2", 8'b1000_0001, 4, 1'b1, 8'h00, 1'b0, 16'd0);

    // back-to-back with s_valid held: 0xA5 MSB-first, then 0x3C LSB-first
    send("bb0", 8'hA5, 1'b1, 16'd0, 1'b1);
    expect_frame("bb0", 8'b1010_0101, 1, 1'b0, 8'h3C, 1'b0, 16'd0);
    @(posedge clk);
    expect_frame("bb1", 8'b0011_1100, 1, 1'b1, 8'h00, 1'b0, 16'd0);

    // abort during bit 3 of 0xFF
    send("ab", 8'hFF, 1'b1, 16'd0, 1'b0);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      check($sformatf("ab c%0d ser", j), ser_out, 1'b1);
      check($sformatf("ab c%0d busy", j), busy, 1'b1);
    end
    abort = 1'b1;
    @(negedge clk);
    check("ab idle busy", busy, 1'b0);
    check("ab idle ser", ser_out, 1'b1);
    check("ab idle done", done, 1'b0);
    s_valid     = 1'b1;
    s_data      = 8'h36;
    s_msb_first = 1'b0;
    div         = 16'd1;
    for (int j = 0; j < 4; j++) begin
      #1;
      check($sformatf("ab hold%0d rdy", j), s_ready, 1'b0);
      @(negedge clk);
      check($sformatf("ab hold%0d busy", j), busy, 1'b0);
      check($sformatf("ab hold%0d done", j), done, 1'b0);
    end
    abort = 1'b0;
    #1;
    check("ab release rdy", s_ready, 1'b1);
    @(posedge clk);
    expect_frame("ab_nx", 8'b0110_1100, 2, 1'b1, 8'h00, 1'b0, 16'd0);

    // async reset between edges mid-frame
    send("rs", 8'h00, 1'b1, 16'd0, 1'b0);
    @(negedge clk);
    check("rs c1 ser", ser_out, 1'b0);
    @(negedge clk);
    check("rs c2 tick", bit_tick, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rs async busy", busy, 1'b0);
    check("rs async ser", ser_out, 1'b1);
    check("rs async tick", bit_tick, 1'b0);
    check("rs async rdy", s_ready, 1'b1);
    check("rs async done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send("rs_nx", 8'hC6, 1'b0, 16'd2, 1'b0);
    expect_frame("rs_nx", 8'b0110_0011, 3, 1'b1, 8'h00, 1'b0, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
